// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - burst/response codes, FSM states and helpers for axi_ram_slave
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int MAX_BURST_LEN = 16;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_WAIT,
    W_RESP
  } w_state_t;

  // Bursts longer than the supported maximum are served as maximum-length bursts.
  function automatic logic [3:0] clamp_len(input logic [7:0] len);
    if (len > 8'(MAX_BURST_LEN - 1)) return 4'(MAX_BURST_LEN - 1);
    return len[3:0];
  endfunction

  // WRAP and the reserved code are not supported; they are answered with SLVERR.
  function automatic logic burst_is_bad(input logic [1:0] burst);
    return (burst == BURST_WRAP) || (burst == BURST_RSVD);
  endfunction

endpackage

// File: rtl/axi_ram_array.sv
// rtl/axi_ram_array.sv - 32-bit word memory, byte-enable write port, registered read port
module axi_ram_array
  import axi_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_be,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  // Byte-masked write; contents are deliberately not reset so data survives a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Read register loads on demand; same-edge write to the same word is not visible yet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axi_ram_slave.sv
// rtl/axi_ram_slave.sv - AXI3 slave RAM with independent read and write burst engines
module axi_ram_slave
  import axi_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int RD_DELAY = 0,
  parameter int B_DELAY  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  // Byte address width; addresses wrap modulo the memory size.
  localparam int         BA_W         = ADDR_W + 2;
  localparam logic [7:0] RD_WAIT_LAST = 8'(RD_DELAY - 1);
  localparam logic [7:0] B_WAIT_LAST  = 8'(B_DELAY - 1);

  // Read engine state
  r_state_t          r_state, r_state_d;
  logic              arready_q, rvalid_q;
  logic [3:0]        r_id_q, r_len_q, r_cnt_q;
  logic [BA_W-1:0]   r_addr_q, r_addr_adv;
  logic [2:0]        r_size_q;
  logic [1:0]        r_burst_q;
  logic              r_err_q;
  logic [7:0]        r_wait_q;
  logic              ar_hs, r_hs, r_last, r_load_first, r_load_next, rd_en;
  logic [ADDR_W-1:0] rd_word;

  // Write engine state
  w_state_t          w_state, w_state_d;
  logic              awready_q, wready_q, bvalid_q;
  logic [3:0]        w_id_q, w_len_q, w_cnt_q, bid_q;
  logic [BA_W-1:0]   w_addr_q, w_addr_adv;
  logic [2:0]        w_size_q;
  logic [1:0]        w_burst_q, bresp_q;
  logic              w_err_q;
  logic [7:0]        w_wait_q;
  logic              aw_hs, w_hs, w_last, w_beat_err, b_hs;

  logic unused_inputs;
  assign unused_inputs = ^{arlock, arcache, arprot, awlock, awcache, awprot,
                           araddr[31:BA_W], awaddr[31:BA_W]};

  // ---------------- read path ----------------
  assign ar_hs        = arready_q & arvalid;
  assign r_hs         = rvalid_q & rready;
  assign r_last       = (r_cnt_q == r_len_q);
  assign r_load_first = (r_state == R_DATA) & ~rvalid_q;
  assign r_load_next  = r_hs & ~r_last;
  assign rd_en        = r_load_first | r_load_next;
  assign r_addr_adv   = (r_burst_q == BURST_FIXED) ? r_addr_q
                                                   : r_addr_q + (BA_W'(1) << r_size_q);
  assign rd_word      = r_load_first ? r_addr_q[BA_W-1:2] : r_addr_adv[BA_W-1:2];

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = r_id_q;
  assign rlast   = rvalid_q & r_last;
  assign rresp   = r_err_q ? RESP_SLVERR : RESP_OKAY;

  // Read FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_state_d;
  end

  // Read FSM next state: accept AR, optional delay, then stream beats until the last one.
  always_comb begin
    r_state_d = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_d = (RD_DELAY > 0) ? R_WAIT : R_DATA;
      R_WAIT:  if (r_wait_q == RD_WAIT_LAST) r_state_d = R_DATA;
      R_DATA:  if (r_hs && r_last) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read datapath: latch the request, count beats, raise/drop rvalid around the burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_err_q   <= 1'b0;
      r_wait_q  <= '0;
    end else begin
      arready_q <= (r_state_d == R_IDLE);
      if (ar_hs) begin
        r_id_q    <= arid;
        r_addr_q  <= araddr[BA_W-1:0];
        r_len_q   <= clamp_len(arlen);
        r_size_q  <= arsize;
        r_burst_q <= arburst;
        r_err_q   <= burst_is_bad(arburst);
        r_cnt_q   <= '0;
        r_wait_q  <= '0;
      end
      if (r_state == R_WAIT) r_wait_q <= r_wait_q + 8'd1;
      if (r_load_first) begin
        rvalid_q <= 1'b1;
      end else if (r_hs) begin
        if (r_last) begin
          rvalid_q <= 1'b0;
        end else begin
          r_addr_q <= r_addr_adv;
          r_cnt_q  <= r_cnt_q + 4'd1;
        end
      end
    end
  end

  // ---------------- write path ----------------
  assign aw_hs      = awready_q & awvalid;
  assign w_hs       = wready_q & wvalid;
  assign w_last     = (w_cnt_q == w_len_q);
  assign w_beat_err = (wid != w_id_q) | (wlast != w_last);
  assign b_hs       = bvalid_q & bready;
  assign w_addr_adv = (w_burst_q == BURST_FIXED) ? w_addr_q
                                                 : w_addr_q + (BA_W'(1) << w_size_q);

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;

  // Write FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_state_d;
  end

  // Write FSM next state: burst length, not wlast, decides when the data phase ends.
  always_comb begin
    w_state_d = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_d = W_DATA;
      W_DATA:  if (w_hs && w_last) w_state_d = (B_DELAY > 0) ? W_WAIT : W_RESP;
      W_WAIT:  if (w_wait_q == B_WAIT_LAST) w_state_d = W_RESP;
      W_RESP:  if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write datapath: latch AW, accumulate beat errors, present B once per burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      w_wait_q  <= '0;
    end else begin
      awready_q <= (w_state_d == W_IDLE);
      wready_q  <= (w_state_d == W_DATA);
      if (aw_hs) begin
        w_id_q    <= awid;
        w_addr_q  <= awaddr[BA_W-1:0];
        w_len_q   <= clamp_len(awlen);
        w_size_q  <= awsize;
        w_burst_q <= awburst;
        w_err_q   <= burst_is_bad(awburst);
        w_cnt_q   <= '0;
        w_wait_q  <= '0;
      end
      if (w_hs) begin
        w_addr_q <= w_addr_adv;
        w_cnt_q  <= w_cnt_q + 4'd1;
        if (w_beat_err) w_err_q <= 1'b1;
      end
      if (w_state == W_WAIT) w_wait_q <= w_wait_q + 8'd1;
      if ((w_state == W_RESP) && !bvalid_q) begin
        bvalid_q <= 1'b1;
        bid_q    <= w_id_q;
        bresp_q  <= w_err_q ? RESP_SLVERR : RESP_OKAY;
      end else if (b_hs) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  axi_ram_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (w_hs),
    .wr_addr(w_addr_q[BA_W-1:2]),
    .wr_data(wdata),
    .wr_be  (wstrb),
    .rd_en  (rd_en),
    .rd_addr(rd_word),
    .rd_data(rdata)
  );

endmodule

// File: tb/tb_axi_ram_slave.sv
// tb/tb_axi_ram_slave.sv - directed self-checking bench for axi_ram_slave
`timescale 1ns/1ps
module tb_axi_ram_slave;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'd2;
  logic [1:0]  arburst = '0;
  logic [1:0]  arlock = '0;
  logic [3:0]  arcache = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;
  logic        rready = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'd2;
  logic [1:0]  awburst = '0;
  logic [1:0]  awlock = '0;
  logic [3:0]  awcache = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  wid = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  int checks = 0;
  int errors = 0;
  int first_valid;

  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];
  logic [3:0]  wids [16];
  logic        wlst [16];
  logic [31:0] rbuf [16];
  logic [1:0]  rrsp [16];
  logic        rlst [16];
  logic [3:0]  ridb [16];

  always #5 clk = ~clk;

  axi_ram_slave dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic prep_w(input logic [3:0] id, input int len);
    for (int i = 0; i < 16; i++) begin
      wids[i] = id;
      wstb[i] = 4'hF;
      wlst[i] = (i == len);
      wdat[i] = '0;
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, output logic [1:0] resp,
                          output logic [3:0] rbid, output logic ok);
    int n;
    ok = 1'b1;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) ok = 1'b0;
    @(posedge clk); #1 awvalid = 1'b0;
    for (int i = 0; i <= int'(len) && i < 16; i++) begin
      wid = wids[i]; wdata = wdat[i]; wstrb = wstb[i]; wlast = wlst[i]; wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!wready && n < 50) begin @(negedge clk); n++; end
      if (!wready) ok = 1'b0;
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) ok = 1'b0;
    resp = bresp; rbid = bid;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, output int beats);
    int n, nb;
    nb = (len > 8'd15) ? 16 : int'(len) + 1;
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 arvalid = 1'b0; rready = 1'b1;
    beats = 0; n = 0; first_valid = -1;
    while (beats < nb && n < 200) begin
      @(negedge clk); n++;
      if (rvalid) begin
        if (first_valid < 0) first_valid = n;
        rbuf[beats] = rdata; rrsp[beats] = rresp; rlst[beats] = rlast; ridb[beats] = rid;
        beats++;
      end
    end
    @(posedge clk); #1 rready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({arready, awready, wready, rvalid, rlast, bvalid} !== 6'b0)
      begin errors++; $display("FAIL reset_ctrl got %b exp 000000", {arready, awready, wready, rvalid, rlast, bvalid}); end
    checks++;
    if ({rid, bid, rresp, bresp} !== 12'h0)
      begin errors++; $display("FAIL reset_ids got %h exp 000", {rid, bid, rresp, bresp}); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (arready !== 1'b0) begin errors++; $display("FAIL ready_early got %b exp 0", arready); end
    @(negedge clk);
    checks++;
    if ({arready, awready} !== 2'b11) begin errors++; $display("FAIL ready_rise got %b exp 11", {arready, awready}); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_rw;
    logic [1:0] resp; logic [3:0] bv; logic ok; int beats;
    prep_w(4'd3, 0); wdat[0] = 32'hDEADBEEF;
    do_write(4'd3, 32'h100, 8'd0, BURST_INCR, resp, bv, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_wr_done got %b exp 1", ok); end
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL single_bresp got %b exp 00", resp); end
    checks++; if (bv !== 4'd3) begin errors++; $display("FAIL single_bid got %0d exp 3", bv); end
    do_read(4'd3, 32'h100, 8'd0, BURST_INCR, beats);
    checks++; if (beats !== 1) begin errors++; $display("FAIL single_beats got %0d exp 1", beats); end
    checks++; if (rbuf[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got %h exp deadbeef", rbuf[0]); end
    checks++; if ({rlst[0], ridb[0], rrsp[0]} !== {1'b1, 4'd3, 2'b00})
      begin errors++; $display("FAIL single_rmeta got %b/%0d/%b exp 1/3/00", rlst[0], ridb[0], rrsp[0]); end
    checks++; if (first_valid !== 2) begin errors++; $display("FAIL read_latency got %0d exp 2", first_valid); end
    @(negedge clk);
    checks++; if ({arready, rvalid} !== 2'b10) begin errors++; $display("FAIL read_end got %b exp 10", {arready, rvalid}); end
    @(posedge clk); #1;
  endtask

  task automatic test_strobes;
    logic [1:0] resp; logic [3:0] bv; logic ok; int beats;
    prep_w(4'd1, 0); wdat[0] = 32'h11223344;
    do_write(4'd1, 32'h0, 8'd0, BURST_INCR, resp, bv, ok);
    prep_w(4'd1, 0); wdat[0] = 32'hAABBCCDD; wstb[0] = 4'b0101;
    do_write(4'd1, 32'h0, 8'd0, BURST_INCR, resp, bv, ok);
    do_read(4'd1, 32'h0, 8'd0, BURST_INCR, beats);
    checks++; if (rbuf[0] !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_data got %h exp 11bb33dd", rbuf[0]); end
  endtask

  task automatic test_incr_stall;
    logic [1:0] resp; logic [3:0] bv; logic ok; int n, b, k;
    prep_w(4'd2, 3);
    for (int i = 0; i < 4; i++) wdat[i] = 32'h10000200 + 32'(4 * i);
    do_write(4'd2, 32'h200, 8'd3, BURST_INCR, resp, bv, ok);
    checks++; if ({ok, resp} !== 3'b100) begin errors++; $display("FAIL incr_wr got %b exp 100", {ok, resp}); end
    arid = 4'd1; araddr = 32'h200; arlen = 8'd3; arsize = 3'd2; arburst = BURST_INCR; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 arvalid = 1'b0;
    b = 0; k = 0;
    while (b < 4 && k < 40) begin
      rready = (k % 2 == 0);
      @(negedge clk);
      if (rvalid) begin
        checks++;
        if (rdata !== 32'h10000200 + 32'(4 * b))
          begin errors++; $display("FAIL stall_data beat %0d got %h exp %h", b, rdata, 32'h10000200 + 32'(4 * b)); end
        checks++;
        if (rlast !== (b == 3)) begin errors++; $display("FAIL stall_last beat %0d got %b exp %b", b, rlast, (b == 3)); end
        if (rready) b++;
      end
      k++;
      @(posedge clk); #1;
    end
    rready = 1'b0;
    checks++; if (b !== 4) begin errors++; $display("FAIL stall_beats got %0d exp 4", b); end
    @(negedge clk);
    checks++; if ({arready, rvalid} !== 2'b10) begin errors++; $display("FAIL stall_end got %b exp 10", {arready, rvalid}); end
    @(posedge clk); #1;
  endtask

  task automatic test_fixed_wrap;
    logic [1:0] resp; logic [3:0] bv; logic ok; int beats;
    prep_w(4'd4, 2); wdat[0] = 32'd1; wdat[1] = 32'd2; wdat[2] = 32'd3;
    do_write(4'd4, 32'h300, 8'd2, BURST_FIXED, resp, bv, ok);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL fixed_bresp got %b exp 00", resp); end
    do_read(4'd4, 32'h300, 8'd0, BURST_INCR, beats);
    checks++; if (rbuf[0] !== 32'd3) begin errors++; $display("FAIL fixed_data got %h exp 3", rbuf[0]); end
    do_read(4'd6, 32'h200, 8'd3, BURST_WRAP, beats);
    checks++; if (beats !== 4) begin errors++; $display("FAIL wrap_beats got %0d exp 4", beats); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rrsp[i] !== 2'b10) begin errors++; $display("FAIL wrap_resp beat %0d got %b exp 10", i, rrsp[i]); end
      checks++;
      if (rbuf[i] !== 32'h10000200 + 32'(4 * i))
        begin errors++; $display("FAIL wrap_data beat %0d got %h exp %h", i, rbuf[i], 32'h10000200 + 32'(4 * i)); end
    end
    checks++; if (rlst[3] !== 1'b1) begin errors++; $display("FAIL wrap_last got %b exp 1", rlst[3]); end
  endtask

  task automatic test_len_clamp;
    int beats;
    do_read(4'd7, 32'h200, 8'd20, BURST_INCR, beats);
    checks++; if (beats !== 16) begin errors++; $display("FAIL clamp_beats got %0d exp 16", beats); end
    checks++; if ({rlst[14], rlst[15]} !== 2'b01) begin errors++; $display("FAIL clamp_last got %b exp 01", {rlst[14], rlst[15]}); end
    checks++; if (rbuf[3] !== 32'h1000020C) begin errors++; $display("FAIL clamp_data got %h exp 1000020c", rbuf[3]); end
  endtask

  task automatic test_protocol_errors;
    logic [1:0] resp; logic [3:0] bv; logic ok; int beats;
    prep_w(4'd4, 1); wdat[0] = 32'h0000AAAA; wdat[1] = 32'h0000BBBB; wlst[0] = 1'b1;
    do_write(4'd4, 32'h400, 8'd1, BURST_INCR, resp, bv, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wlast_beats got %b exp 1", ok); end
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL wlast_bresp got %b exp 10", resp); end
    do_read(4'd4, 32'h404, 8'd0, BURST_INCR, beats);
    checks++; if (rbuf[0] !== 32'h0000BBBB) begin errors++; $display("FAIL wlast_beat2 got %h exp 0000bbbb", rbuf[0]); end
    checks++; if (rrsp[0] !== 2'b00) begin errors++; $display("FAIL rresp_clear got %b exp 00", rrsp[0]); end
    prep_w(4'd6, 0); wdat[0] = 32'h5555;
    do_write(4'd5, 32'h408, 8'd0, BURST_INCR, resp, bv, ok);
    checks++; if ({resp, bv} !== {2'b10, 4'd5}) begin errors++; $display("FAIL wid_err got %b/%0d exp 10/5", resp, bv); end
    prep_w(4'd5, 0); wdat[0] = 32'h6666;
    do_write(4'd5, 32'h408, 8'd0, BURST_INCR, resp, bv, ok);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL bresp_clear got %b exp 00", resp); end
  endtask

  task automatic test_collision;
    logic [1:0] resp; logic [3:0] bv; logic ok; int beats;
    prep_w(4'd7, 0); wdat[0] = 32'h111;
    do_write(4'd7, 32'h500, 8'd0, BURST_INCR, resp, bv, ok);
    prep_w(4'd7, 0); wdat[0] = 32'h222;
    fork
      do_write(4'd7, 32'h500, 8'd0, BURST_INCR, resp, bv, ok);
      do_read(4'd7, 32'h500, 8'd0, BURST_INCR, beats);
    join
    checks++; if (rbuf[0] !== 32'h111) begin errors++; $display("FAIL collide_old got %h exp 111", rbuf[0]); end
    checks++; if ({ok, resp} !== 3'b100) begin errors++; $display("FAIL collide_wr got %b exp 100", {ok, resp}); end
    do_read(4'd7, 32'h500, 8'd0, BURST_INCR, beats);
    checks++; if (rbuf[0] !== 32'h222) begin errors++; $display("FAIL collide_new got %h exp 222", rbuf[0]); end
  endtask

  task automatic test_reset_mid;
    int n, beats;
    arid = 4'd2; araddr = 32'h200; arlen = 8'd3; arsize = 3'd2; arburst = BURST_INCR; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 arvalid = 1'b0; rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rvalid, rdata} !== {1'b1, 32'h10000204})
      begin errors++; $display("FAIL mid_beat2 got %b/%h exp 1/10000204", rvalid, rdata); end
    reset = 1'b1;
    #1;
    checks++; if ({rvalid, rlast, arready} !== 3'b000) begin errors++; $display("FAIL mid_drop got %b exp 000", {rvalid, rlast, arready}); end
    @(posedge clk); #1 reset = 1'b0; rready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({arready, awready} !== 2'b11) begin errors++; $display("FAIL mid_ready got %b exp 11", {arready, awready}); end
    @(posedge clk); #1;
    do_read(4'd2, 32'h200, 8'd3, BURST_INCR, beats);
    checks++; if (beats !== 4) begin errors++; $display("FAIL mid_beats got %0d exp 4", beats); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rbuf[i] !== 32'h10000200 + 32'(4 * i))
        begin errors++; $display("FAIL mid_mem beat %0d got %h exp %h", i, rbuf[i], 32'h10000200 + 32'(4 * i)); end
    end
  endtask

  initial begin
    test_reset();
    test_single_rw();
    test_strobes();
    test_incr_stall();
    test_fixed_wrap();
    test_len_clamp();
    test_protocol_errors();
    test_collision();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
